if_prefetch_queue: RTL and testbench
====================================

# if_prefetch_queue

Instruction-fetch front end that drives the word address of the instruction ROM (`ROM_D`: 10-bit `a`, 32-bit `spo`, combinational read) and buffers fetched instructions with their PCs in a small FIFO. It feeds the decode stage through a valid/ready handshake. It sits between the ROM and the IF/ID boundary of the pipelined CPU, absorbing decode stalls and discarding wrong-path instructions on redirect.

## Interface
- `DEPTH`, 4: queue entries; power of two, at least 2.
- `ADDR_W`, 10: ROM word-address width.
- `RESET_PC`, 32'h0000_0000: byte PC after reset; bits [1:0] must be 0.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rom_addr`  out  ADDR_W  word address to ROM, equal to `pc[ADDR_W+1:2]` (combinational from `pc` register).
- `rom_data`  in  32  ROM read data for `rom_addr`, valid in the same cycle.
- `redirect`  in  1  branch/jump taken; flush queue and reload PC.
- `redirect_pc`  in  32  target byte address; bits [1:0] ignored (treated as 0).
- `id_valid`  out  1  head entry available.
- `id_ready`  in  1  decode accepts head this cycle.
- `id_instr`  out  32  head instruction; 0 when empty.
- `id_pc`  out  32  byte PC of head; 0 when empty.

## Operation
- State: 32-bit `pc`, queue storage, rd/wr pointers, and occupancy `count` (0..DEPTH).
- `pop = id_valid & id_ready`. `push = ~redirect & (count < DEPTH | pop)`.
- Push: write {`pc`, `rom_data`} at wr pointer; `pc <= pc + 4`.
- Pop: advance rd pointer. Push and pop in the same cycle leave `count` unchanged.
- Redirect has priority over everything. On `redirect`: `count <= 0`, pointers reset, `pc <= {redirect_pc[31:2], 2'b00}`, no push that cycle. A pop in the same cycle is still a completed transfer, since decode consumed the old head.
- Full (`count == DEPTH`) with no pop: no fetch; `pc` holds; `rom_addr` stable.
- Empty: `id_valid = 0`; `id_instr` and `id_pc` are 0.
- PC arithmetic is modulo 2^32. `rom_addr` wraps naturally at 2^ADDR_W words; this is not an error.
- `id_valid = (count != 0)`. Outputs come from registered queue state only, with no combinational path from `rom_data` or `id_ready` to `id_*`.

## Timing
- Reset values: `pc = RESET_PC`, `count = 0`, `id_valid = 0`, `id_instr = 0`, `id_pc = 0`, `rom_addr = RESET_PC[ADDR_W+1:2]`.
- `rst` asserted mid-operation clears all state asynchronously; queued entries are lost.
- Fetch latency: an instruction addressed in cycle t is visible at the head no earlier than cycle t+1.
- After `rst` deasserts: first edge fetches `RESET_PC`; `id_valid = 1` in the following cycle.
- Redirect sampled at edge t: `rom_addr` = target in cycle t+1; target instruction is at the head with `id_valid` in t+2. This gives 1 bubble cycle.
- With `id_ready` held high and no redirect, throughput is 1 instruction per cycle and `count` stays at 1.
- `id_ready` low for N cycles fills the queue to DEPTH after DEPTH cycles, then fetch stalls.
- `redirect` and `rst` are never both expected; `rst` wins.

## Structure
- Shared package `cpu_pkg`:
  - `RESET_PC` default
  - `INSTR_W = 32`
  - `PC_INC = 4`
  - `fetch_entry_t` struct {pc[31:0], instr[31:0]}
- One sub-module, `if_sync_fifo` (DEPTH, entry width, push, pop, flush, count/full/empty), holds the storage and pointers.
- The top level holds only the PC, push/pop/redirect logic, and the ROM address port.

## Test plan
- Reset then `id_ready = 1`, ROM word k = 32'h1000_0000+k: `id_pc` = 0, 4, 8, … with `id_instr` = 32'h1000_0000, …0001, …0002; `id_valid` first high in cycle 2.
- `id_ready = 0` for 10 cycles: `count` saturates at 4, `rom_addr` holds at 4. On release, PCs 0, 4, 8, 12, 16 drain in order with no gap or duplicate.
- `redirect = 1`, `redirect_pc = 32'h0000_0103` while queue full: next head is PC 32'h100, instr = ROM[64], arriving 2 cycles later; no old entry appears.
- Redirect coincident with pop: popped entry counts once; the following head is the target.
- `rst` pulsed asynchronously (between edges) with queue at 3 entries: `id_valid` drops immediately; after release, fetch restarts at `RESET_PC`.
- PC at 32'h0000_0FFC: `rom_addr` goes 1023 then 0; `id_pc` reads 32'h0000_1000 for the wrapped fetch.

Source files
------------

// File: rtl/cpu_pkg.sv
// Purpose : shared fetch-side types and constants for the pipelined CPU front end.
// Latency : n/a (package only).
// Backpr. : n/a. Exports RESET_PC default, INSTR_W, PC_INC and fetch_entry_t {pc, instr}.
package cpu_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          INSTR_W  = 32;
  localparam logic [31:0] PC_INC   = 32'd4;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_sync_fifo.sv
// Purpose : synchronous FIFO holding fetched entries; storage plus rd/wr pointers and occupancy.
// Latency : a pushed entry is readable at the head the cycle after the push edge.
// Backpr. : caller must not push when full without a same-cycle pop; flush empties it in one edge.
// Ports   : clk, rst (async high); push_i/pop_i/flush_i; wdata_i -> rdata_o (head, raw);
//           count_o (0..DEPTH), full_o, empty_o.
module if_sync_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 64,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic [PW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW:0]   CNT_ONE  = {{PW{1'b0}}, 1'b1};
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [PW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  // Flush wins: nothing is written on a flush edge.
  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_ONE;
      if (do_pop)  rd_q <= rd_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: the head is only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/if_prefetch_queue.sv
// Purpose : instruction-fetch front end; drives ROM word address, queues {pc, instr} for decode.
// Latency : fetched word reaches the head 1 cycle after its address; redirect target after 2.
// Backpr. : id_ready low fills the queue to DEPTH, then pc and rom_addr hold until a pop.
// Ports   : clk, rst (async high); rom_addr/rom_data to ROM; redirect/redirect_pc from EX;
//           id_valid/id_ready/id_instr/id_pc to decode (registered state only).
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [31:0]       id_instr,
  output logic [31:0]       id_pc
);

  import cpu_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]  pc_q, pc_d;
  fetch_entry_t wr_entry, rd_entry;
  logic [CW-1:0] count;
  logic          full, empty;
  logic          push, pop;

  assign id_valid = (count != '0);
  assign pop      = id_valid & id_ready;
  // A same-cycle pop frees a slot, so a full queue can still fetch while draining.
  assign push     = ~redirect & (~full | pop);

  assign rom_addr = pc_q[ADDR_W+1:2];
  assign wr_entry = '{pc: pc_q, instr: rom_data};

  always_comb begin
    pc_d = pc_q;
    if (redirect)  pc_d = {redirect_pc[31:2], 2'b00};
    else if (push) pc_d = pc_q + PC_INC;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  if_sync_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .wdata_i (wr_entry),
    .rdata_o (rd_entry),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // Stale storage must not leak out when the queue is empty.
  assign id_instr = empty ? '0 : rd_entry.instr;
  assign id_pc    = empty ? '0 : rd_entry.pc;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Purpose : directed self-checking bench for if_prefetch_queue with a combinational ROM model.
// Latency : checks sampled 1 time unit after each rising edge.
// Backpr. : exercises stall/fill, drain, redirect (full and with pop), async reset, address wrap.
module tb_if_prefetch_queue;

  logic        clk;
  logic        rst;
  logic [9:0]  rom_addr;
  logic [31:0] rom_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  int n_cmp = 0;
  int n_bad = 0;

  // ROM word k holds 32'h1000_0000 + k.
  assign rom_data = 32'h1000_0000 + {22'd0, rom_addr};

  if_prefetch_queue #(
    .DEPTH    (4),
    .ADDR_W   (10),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_pc       (id_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    id_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_valid",    {31'd0, id_valid}, 32'd0);
    chk("rst_instr",    id_instr,          32'd0);
    chk("rst_pc",       id_pc,             32'd0);
    chk("rst_rom_addr", {22'd0, rom_addr}, 32'd0);

    rst = 1'b0;
    #2;
    chk("pre_edge_valid", {31'd0, id_valid}, 32'd0);

    // Streaming at one instruction per cycle
    id_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("stream_valid",    {31'd0, id_valid}, 32'd1);
      chk("stream_pc",       id_pc,             32'(4 * k));
      chk("stream_instr",    id_instr,          32'h1000_0000 + 32'(k));
      chk("stream_rom_addr", {22'd0, rom_addr}, 32'(k + 1));
    end

    // Two stalled edges bring the queue to 3 entries (20, 24, 28)
    id_ready = 1'b0;
    tick();
    tick();
    chk("fill3_pc",       id_pc,             32'd20);
    chk("fill3_rom_addr", {22'd0, rom_addr}, 32'd8);

    // Asynchronous reset pulse between edges
    #2 rst = 1'b1;
    #1;
    chk("arst_valid",    {31'd0, id_valid}, 32'd0);
    chk("arst_pc",       id_pc,             32'd0);
    chk("arst_rom_addr", {22'd0, rom_addr}, 32'd0);
    #2 rst = 1'b0;

    // Stall for 10 cycles from reset: queue fills with 0,4,8,12 and pc holds at 16
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("stall_valid",    {31'd0, id_valid}, 32'd1);
      chk("stall_pc",       id_pc,             32'd0);
      chk("stall_rom_addr", {22'd0, rom_addr}, (k < 3) ? 32'(k + 1) : 32'd4);
    end

    // Release: heads 4..20 follow 0 with no gap or duplicate
    id_ready = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      tick();
      chk("drain_valid", {31'd0, id_valid}, 32'd1);
      chk("drain_pc",    id_pc,             32'(4 * j));
      chk("drain_instr", id_instr,          32'h1000_0000 + 32'(j));
    end

    // Redirect while full, no pop
    id_ready    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    chk("redir_bubble_valid", {31'd0, id_valid}, 32'd0);
    chk("redir_bubble_pc",    id_pc,             32'd0);
    chk("redir_bubble_instr", id_instr,          32'd0);
    chk("redir_rom_addr",     {22'd0, rom_addr}, 32'h40);
    tick();
    chk("redir_head_valid", {31'd0, id_valid}, 32'd1);
    chk("redir_head_pc",    id_pc,             32'h0000_0100);
    chk("redir_head_instr", id_instr,          32'h1000_0040);
    chk("redir_next_addr",  {22'd0, rom_addr}, 32'h41);

    // Redirect coincident with a pop of head 0x100, target near the top of ROM
    id_ready    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0FFC;
    tick();
    redirect = 1'b0;
    chk("rpop_bubble_valid", {31'd0, id_valid}, 32'd0);
    chk("rpop_rom_addr",     {22'd0, rom_addr}, 32'd1023);
    tick();
    chk("wrap_head_valid", {31'd0, id_valid}, 32'd1);
    chk("wrap_head_pc",    id_pc,             32'h0000_0FFC);
    chk("wrap_head_instr", id_instr,          32'h1000_03FF);
    chk("wrap_rom_addr",   {22'd0, rom_addr}, 32'd0);
    tick();
    chk("wrap2_pc",       id_pc,             32'h0000_1000);
    chk("wrap2_instr",    id_instr,          32'h1000_0000);
    chk("wrap2_rom_addr", {22'd0, rom_addr}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
